// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit
// Program counter and fetch stage between a 1-cycle-latency synchronous
// instruction memory and the decode stage. Pairs each returned word with
// its PC, holds the output across decode stalls and inserts a single
// bubble on a redirect (branch/jump).
//
// Ports:
//   clock           - single clock, rising edge
//   reset           - asynchronous, active-high
//   stall           - decode cannot accept this cycle
//   redirect_valid  - load redirect_addr as the next fetch PC
//   redirect_addr   - redirect target word address
//   Instruction_in  - registered read data from instruction memory
//   Adress          - fetch address to instruction memory (straight from a flop)
//   Instruction_out - instruction to decode, 0 when not valid
//   pc_out          - word address of Instruction_out
//   valid           - Instruction_out/pc_out are meaningful
//   fetch_count     - instructions accepted by decode, saturating
module instruction_fetch_unit #(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned INSTR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0,
    parameter int unsigned COUNT_WIDTH = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   stall,
    input  logic                   redirect_valid,
    input  logic [ADDR_WIDTH-1:0]  redirect_addr,
    input  logic [INSTR_WIDTH-1:0] Instruction_in,
    output logic [ADDR_WIDTH-1:0]  Adress,
    output logic [INSTR_WIDTH-1:0] Instruction_out,
    output logic [ADDR_WIDTH-1:0]  pc_out,
    output logic                   valid,
    output logic [COUNT_WIDTH-1:0] fetch_count
);

    logic [ADDR_WIDTH-1:0]  fetch_pc_q,    fetch_pc_d;
    logic [ADDR_WIDTH-1:0]  out_pc_q,      out_pc_d;
    logic                   out_valid_q,   out_valid_d;
    logic                   hold_valid_q,  hold_valid_d;
    logic [INSTR_WIDTH-1:0] hold_instr_q,  hold_instr_d;
    logic [COUNT_WIDTH-1:0] fetch_count_q, fetch_count_d;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        out_pc_d      = out_pc_q;
        out_valid_d   = out_valid_q;
        hold_valid_d  = hold_valid_q;
        hold_instr_d  = hold_instr_q;
        fetch_count_d = fetch_count_q;

        if (redirect_valid) begin
            // Redirect beats stall: any held word is stale and is dropped.
            fetch_pc_d   = redirect_addr;
            out_valid_d  = 1'b0;
            hold_valid_d = 1'b0;
        end else if (stall && out_valid_q) begin
            // The memory keeps reading fetch_pc (one ahead of out_pc), so
            // the word for out_pc is only on Instruction_in during the first
            // stalled cycle; capture it then.
            if (!hold_valid_q) begin
                hold_instr_d = Instruction_in;
                hold_valid_d = 1'b1;
            end
        end else begin
            out_pc_d     = fetch_pc_q;
            out_valid_d  = 1'b1;
            fetch_pc_d   = fetch_pc_q + 1'b1;
            hold_valid_d = 1'b0;
        end

        if (out_valid_q && !stall && !redirect_valid && (fetch_count_q != '1)) begin
            fetch_count_d = fetch_count_q + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fetch_pc_q    <= RESET_PC;
            out_pc_q      <= '0;
            out_valid_q   <= 1'b0;
            hold_valid_q  <= 1'b0;
            hold_instr_q  <= '0;
            fetch_count_q <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            out_pc_q      <= out_pc_d;
            out_valid_q   <= out_valid_d;
            hold_valid_q  <= hold_valid_d;
            hold_instr_q  <= hold_instr_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign Adress          = fetch_pc_q;
    assign pc_out          = out_pc_q;
    assign valid           = out_valid_q;
    assign fetch_count     = fetch_count_q;
    assign Instruction_out = !out_valid_q ? '0 :
                             (hold_valid_q ? hold_instr_q : Instruction_in);

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Testbench for instruction_fetch_unit: directed scenarios plus a randomized
// stall/redirect run, all checked against a PC-stream reference model.
module tb_instruction_fetch_unit;

    localparam int AW = 10;
    localparam int IW = 32;
    localparam int CW = 16;
    localparam int OW = 1 + AW + IW + AW + CW;

    logic          clock = 1'b0;
    logic          reset;
    logic          stall;
    logic          redirect_valid;
    logic [AW-1:0] redirect_addr;
    logic [IW-1:0] instr_in = '0;
    logic [AW-1:0] adress;
    logic [IW-1:0] instr_out;
    logic [AW-1:0] pc_out;
    logic          valid;
    logic [CW-1:0] fetch_count;

    int n_checks = 0;
    int n_pass   = 0;

    instruction_fetch_unit #(
        .ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .RESET_PC('0), .COUNT_WIDTH(CW)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .Instruction_in (instr_in),
        .Adress         (adress),
        .Instruction_out(instr_out),
        .pc_out         (pc_out),
        .valid          (valid),
        .fetch_count    (fetch_count)
    );

    always #5 clock = ~clock;

    function automatic logic [IW-1:0] rom(input logic [AW-1:0] a);
        return 32'hA000_0000 + IW'(a);
    endfunction

    // Instruction memory: registered read, one cycle of latency.
    always @(posedge clock) instr_in <= rom(adress);

    // Reference model: what decode should see, in terms of the PC sequence.
    // m_next is the PC that will be presented on the next advance.
    logic          m_valid;
    logic [AW-1:0] m_pc;
    logic [AW-1:0] m_next;
    int            m_count;

    task automatic model_reset();
        m_valid = 1'b0;
        m_pc    = '0;
        m_next  = '0;
        m_count = 0;
    endtask

    function automatic logic [OW-1:0] expected();
        return {m_valid, m_pc, (m_valid ? rom(m_pc) : {IW{1'b0}}), m_next, CW'(m_count)};
    endfunction

    wire [OW-1:0] observed = {valid, pc_out, instr_out, adress, fetch_count};

    // One clock edge with the currently driven inputs; model follows the
    // same edge, outputs sampled 1 time unit later.
    task automatic step();
        @(posedge clock);
        if (m_valid && !stall && !redirect_valid && m_count < (1 << CW) - 1)
            m_count++;
        if (redirect_valid) begin
            m_valid = 1'b0;
            m_next  = redirect_addr;
        end else if (!(stall && m_valid)) begin
            m_valid = 1'b1;
            m_pc    = m_next;
            m_next  = m_next + 1'b1;
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_addr = '0;
        model_reset();
        #12;
        n_checks++;
        if (observed !== expected())
            $display("FAIL reset_state: got %h want %h", observed, expected());
        else n_pass++;
        reset = 1'b0;
    endtask

    task automatic test_stream();
        for (int i = 0; i < 9; i++) begin
            step();
            n_checks++;
            if (pc_out !== AW'(i) || instr_out !== rom(AW'(i)) || valid !== 1'b1 ||
                observed !== expected())
                $display("FAIL stream[%0d]: got %h want pc %0d instr %h (model %h)",
                         i, observed, i, rom(AW'(i)), expected());
            else n_pass++;
        end
        n_checks++;
        if (fetch_count !== CW'(8))
            $display("FAIL stream_count: got %0d want 8", fetch_count);
        else n_pass++;
    endtask

    task automatic test_stall();
        logic [CW-1:0] base;
        redirect_valid = 1'b1; redirect_addr = AW'(5);
        step();
        redirect_valid = 1'b0;
        step();
        base  = CW'(m_count);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (pc_out !== AW'(5) || instr_out !== 32'hA000_0005 || adress !== AW'(6) ||
                fetch_count !== base || observed !== expected())
                $display("FAIL stall_hold[%0d]: got %h want pc 5 instr A0000005 adr 6 cnt %0d",
                         i, observed, base);
            else n_pass++;
        end
        stall = 1'b0;
        for (int i = 6; i < 8; i++) begin
            step();
            n_checks++;
            if (pc_out !== AW'(i) || instr_out !== rom(AW'(i)) || observed !== expected())
                $display("FAIL stall_release[%0d]: got %h want %h", i, observed, expected());
            else n_pass++;
        end
    endtask

    task automatic test_redirect();
        redirect_valid = 1'b1; redirect_addr = AW'(10);
        step();
        redirect_valid = 1'b0;
        step();
        redirect_valid = 1'b1; redirect_addr = AW'(100);
        step();
        redirect_valid = 1'b0;
        n_checks++;
        if (valid !== 1'b0 || instr_out !== '0 || observed !== expected())
            $display("FAIL redirect_bubble: got %h want %h", observed, expected());
        else n_pass++;
        step();
        n_checks++;
        if (pc_out !== AW'(100) || instr_out !== 32'hA000_0064 || observed !== expected())
            $display("FAIL redirect_target: got %h want pc 100 instr A0000064", observed);
        else n_pass++;
    endtask

    task automatic test_redirect_stall();
        step();
        stall = 1'b1;
        step();
        step();
        redirect_valid = 1'b1; redirect_addr = AW'(20);
        step();
        redirect_valid = 1'b0; stall = 1'b0;
        n_checks++;
        if (valid !== 1'b0 || instr_out !== '0 || observed !== expected())
            $display("FAIL redirect_stall_bubble: got %h want %h", observed, expected());
        else n_pass++;
        for (int i = 20; i < 22; i++) begin
            step();
            n_checks++;
            if (pc_out !== AW'(i) || instr_out !== rom(AW'(i)) || observed !== expected())
                $display("FAIL redirect_stall_target[%0d]: got %h want %h", i, observed, expected());
            else n_pass++;
        end
    endtask

    task automatic test_wrap();
        logic [AW-1:0] pcs [4];
        pcs[0] = AW'(1022); pcs[1] = AW'(1023); pcs[2] = AW'(0); pcs[3] = AW'(1);
        redirect_valid = 1'b1; redirect_addr = AW'(1022);
        step();
        redirect_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            n_checks++;
            if (pc_out !== pcs[i] || instr_out !== rom(pcs[i]) || valid !== 1'b1 ||
                observed !== expected())
                $display("FAIL wrap[%0d]: got %h want pc %0d instr %h", i, observed, pcs[i], rom(pcs[i]));
            else n_pass++;
        end
    endtask

    task automatic test_async_reset();
        redirect_valid = 1'b1; redirect_addr = AW'(7);
        step();
        redirect_valid = 1'b0;
        step();
        stall = 1'b1;
        step();
        step();
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        n_checks++;
        if (valid !== 1'b0 || adress !== '0 || fetch_count !== '0 || instr_out !== '0 ||
            observed !== expected())
            $display("FAIL async_reset: got %h want %h", observed, expected());
        else n_pass++;
        stall = 1'b0;
        #2;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            n_checks++;
            if (pc_out !== AW'(i) || instr_out !== rom(AW'(i)) || observed !== expected())
                $display("FAIL restart[%0d]: got %h want %h", i, observed, expected());
            else n_pass++;
        end
    endtask

    task automatic test_random();
        int errs = 0;
        for (int i = 0; i < 500; i++) begin
            stall          = ($urandom_range(99) < 35);
            redirect_valid = ($urandom_range(99) < 10);
            redirect_addr  = AW'($urandom());
            step();
            n_checks++;
            if (observed !== expected()) begin
                if (errs < 10)
                    $display("FAIL random[%0d]: got %h want %h", i, observed, expected());
                errs++;
            end else n_pass++;
        end
        stall = 1'b0; redirect_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_redirect_stall();
        test_wrap();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Program-counter and fetch stage sitting directly upstream of the instruction memory (10-bit word address, registered synchronous read, 1-cycle latency) and feeding the decode stage. Drives the memory address, pairs each returned word with its PC, and presents a valid instruction to decode. Supports decode stall via an internal hold register and 1-bubble redirect for branches and jumps. Keeps a consumed-instruction counter for bring-up.

Parameters:
ADDR_WIDTH, 10, instruction word-address width (matches memory depth 1024)
INSTR_WIDTH, 32, instruction width
RESET_PC, 0, first fetch address after reset
COUNT_WIDTH, 16, width of retired-fetch counter

Ports:
clock  in  1  single clock, all state on rising edge
reset  in  1  asynchronous, active-high; clears all state immediately
stall  in  1  decode cannot accept; hold current output
redirect_valid  in  1  load new PC (branch/jump taken)
redirect_addr  in  ADDR_WIDTH  redirect target word address
Instruction_in  in  INSTR_WIDTH  registered read data from instruction memory
Adress  out  ADDR_WIDTH  address to instruction memory; equals fetch_pc register, no combinational path from inputs
Instruction_out  out  INSTR_WIDTH  instruction to decode; 0 (NOP) when valid=0
pc_out  out  ADDR_WIDTH  address of Instruction_out
valid  out  1  Instruction_out/pc_out meaningful
fetch_count  out  COUNT_WIDTH  instructions consumed by decode (valid & !stall), saturating

Behaviour:
- State: fetch_pc, out_pc, out_valid, hold_valid, hold_instr, fetch_count.
- Reset (async, any time incl. mid-stall/mid-redirect): fetch_pc=RESET_PC, out_pc=0, out_valid=0, hold_valid=0, hold_instr=0, fetch_count=0. Outputs: Adress=RESET_PC, valid=0, Instruction_out=0, pc_out=0.
- Instruction_out = !out_valid ? 0 : (hold_valid ? hold_instr : Instruction_in). valid=out_valid, pc_out=out_pc.
- Memory contract: word read at Adress during cycle n appears on Instruction_in in cycle n+1.
- Per rising edge, priority order:
  1. redirect_valid=1 (wins over stall): fetch_pc<=redirect_addr, out_valid<=0, hold_valid<=0. Exactly one bubble; the following edge issues redirect_addr.
  2. stall=1 and out_valid=1: fetch_pc and out_pc unchanged; if hold_valid=0 then hold_instr<=Instruction_in, hold_valid<=1; else hold unchanged. Memory keeps rereading fetch_pc (= out_pc+1), so data is correct on release.
  3. Otherwise (advance; stall with out_valid=0 does not block): out_pc<=fetch_pc, out_valid<=1, fetch_pc<=fetch_pc+1 mod 2^ADDR_WIDTH, hold_valid<=0.
- Latency: first valid output in the 1st cycle after the first edge following reset release (pc_out=RESET_PC); steady state 1 instruction/cycle.
- Wrap-around: fetch_pc 1023 -> 0 with no bubble; redirect_addr used as-is.
- fetch_count increments on each edge where valid=1, stall=0, redirect_valid=0; saturates at all-ones.
- A redirect during a stall discards the held instruction; it is not counted.
- Single-cycle stall costs exactly one cycle; no instruction is duplicated or dropped.

Test Plan:
- Reset/stream: memory model rom[i]=32'hA000_0000+i, reset released, no stall -> cycle 1 valid=1 pc_out=0 Instruction_out=A0000000, then pc 1,2,3... each cycle; fetch_count=8 after 8 valid cycles.
- Stall: stall=1 for 3 cycles while pc_out=5 -> pc_out=5, Instruction_out=A0000005 held all 3 cycles, Adress=6; after release next cycles show pc 6, 7; fetch_count not incremented during stall.
- Redirect: redirect_valid=1, redirect_addr=100 while pc_out=10 -> next cycle valid=0, Instruction_out=0; following cycle pc_out=100, Instruction_out=A0000064.
- Redirect+stall same edge: stall=1, redirect_valid=1, redirect_addr=20 with hold_valid=1 -> hold discarded, bubble, then pc_out=20, no stale held word appears.
- Wrap: redirect to 1022, no stall -> pc_out 1022, 1023, 0, 1 with Instruction_out A00003FE, A00003FF, A0000000, A0000001.
- Async reset mid-stall: assert reset between edges while stalled at pc 7 -> valid=0, Adress=0, fetch_count=0 immediately without a clock edge; restart matches scenario 1.
